clk_meas: RTL and testbench

- Frequency/duty meter for a slow, locally generated clock, such as a divided clock from our clock divider.
- Samples the incoming slow clock in the system clock domain and measures, in system-clock cycles:
  - the period between consecutive rising edges;
  - the high time within that period.
- Reports each completed measurement with a one-cycle valid pulse. Flags a timeout when the input stops toggling.
- Sits beside the divider in the npc top level and is used for self-check and debug readout.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/clk_meas.sv | 129 ++++++++++++
 tb/tb_clk_meas.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clk_meas slow-clock period/duty meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Counters restart at 1 because the rise cycle itself is part of the new period.
  localparam int unsigned CNT_RST = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus registered-sample edge detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      s_d     <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clk_meas.sv
// Measures period and high time of a slow clock in system-clock cycles, with stall timeout.
module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(CNT_RST);

  state_e           state, state_nxt;
  logic             s, rise, fall;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic             hi_run;
  logic             load, restart, clr, to_set;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(sig_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A rise in the same cycle as the timeout threshold takes priority.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    restart   = 1'b0;
    clr       = 1'b0;
    to_set    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          clr       = 1'b1;
          state_nxt = ARM;
        end
        ARM: begin
          if (rise) begin
            restart   = 1'b1;
            state_nxt = MEASURE;
          end else if (per_cnt >= TO_LIM) begin
            to_set = 1'b1;
            clr    = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            load    = 1'b1;
            restart = 1'b1;
          end else if (per_cnt >= TO_LIM) begin
            to_set    = 1'b1;
            clr       = 1'b1;
            state_nxt = ARM;
          end
        end
        default: begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      endcase
    end
  end

  // Counter stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      hi_run  <= 1'b0;
    end else if (clr) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      hi_run  <= 1'b0;
    end else if (restart) begin
      per_cnt <= CNT_ONE;
      hi_cnt  <= CNT_ONE;
      hi_run  <= 1'b1;
    end else if (state == ARM) begin
      per_cnt <= per_cnt + CNT_ONE;
    end else if (state == MEASURE) begin
      per_cnt <= per_cnt + CNT_ONE;
      if (fall)             hi_run <= 1'b0;
      else if (hi_run && s) hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  // Result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
        timeout   <= 1'b0;
      end else if (to_set) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: square waves of several duties, timeout, enable and reset.
module tb_clk_meas;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, timeout;

  int n_vec = 0;
  int n_err = 0;
  int wide_cnt = 0;
  logic vld_prev = 1'b0;
  logic [CNT_W-1:0] q_per[$];
  logic [CNT_W-1:0] q_hi[$];

  clk_meas #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TIMEOUT    (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Record every reported measurement and any valid pulse longer than one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        q_per.push_back(period);
        q_hi.push_back(high_time);
      end
      if (valid && vld_prev) wide_cnt++;
      vld_prev = valid;
    end else begin
      vld_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      sig_in = 1'b1;
      cycles(h);
      sig_in = 1'b0;
      cycles(l);
    end
  endtask

  task automatic clr_q();
    q_per.delete();
    q_hi.delete();
  endtask

  task automatic chk_entry(input string tag, input int idx, input int ep, input int eh);
    if (idx < q_per.size()) begin
      chk({tag, "_per"}, 32'(q_per[idx]), 32'(ep));
      chk({tag, "_hi"}, 32'(q_hi[idx]), 32'(eh));
    end else begin
      chk({tag, "_missing"}, 32'(q_per.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset state
    cycles(3);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // 5 high / 5 low: first rise arms, next three report
    rst_n = 1'b1;
    en    = 1'b1;
    clr_q();
    wave(5, 5, 4);
    chk("w55_count", 32'(q_per.size()), 3);
    for (int i = 0; i < 3; i++) chk_entry("w55", i, 10, 5);

    // Toggle every 4 cycles, as a divider with count_limit=3 would
    clr_q();
    wave(4, 4, 4);
    chk("w44_count", 32'(q_per.size()), 4);
    chk_entry("w44_old", 0, 10, 5);
    for (int i = 1; i < 4; i++) chk_entry("w44", i, 8, 4);

    // Asymmetric duty
    clr_q();
    wave(3, 12, 3);
    chk("w312_count", 32'(q_per.size()), 3);
    chk_entry("w312_old", 0, 8, 4);
    chk_entry("w312", 1, 15, 3);
    chk_entry("w312", 2, 15, 3);

    clr_q();
    wave(7, 2, 3);
    chk("w72_count", 32'(q_per.size()), 3);
    chk_entry("w72_old", 0, 15, 3);
    chk_entry("w72", 1, 9, 7);
    chk_entry("w72", 2, 9, 7);

    // Stall low after a 10-cycle measurement
    clr_q();
    wave(5, 5, 2);
    chk_entry("pre_to", 1, 10, 5);
    cycles(5);
    chk("to_early", 32'(timeout), 0);
    cycles(25);
    chk("to_set", 32'(timeout), 1);
    chk("to_period_hold", 32'(period), 10);
    chk("to_high_hold", 32'(high_time), 5);

    // Restart toggling clears timeout on the next report
    clr_q();
    wave(5, 5, 3);
    chk("restart_count", 32'(q_per.size()), 2);
    chk_entry("restart", 0, 10, 5);
    chk("to_clear", 32'(timeout), 0);

    // Enable dropped during the low phase, toggling continues while disabled
    clr_q();
    cycles(2);
    en = 1'b0;
    cycles(3);
    wave(5, 5, 2);
    chk("dis_count", 32'(q_per.size()), 0);
    chk("dis_period_hold", 32'(period), 10);
    chk("dis_high_hold", 32'(high_time), 5);
    en = 1'b1;
    wave(5, 5, 3);
    chk("reen_count", 32'(q_per.size()), 2);
    chk_entry("reen", 1, 10, 5);

    // Asynchronous reset in the middle of a high phase
    sig_in = 1'b1;
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_high", 32'(high_time), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_timeout", 32'(timeout), 0);
    @(negedge clk);
    clr_q();
    sig_in = 1'b0;
    rst_n  = 1'b1;
    cycles(5);
    wave(5, 5, 3);
    chk("post_rst_count", 32'(q_per.size()), 2);
    chk_entry("post_rst", 0, 10, 5);
    chk_entry("post_rst", 1, 10, 5);

    chk("valid_width", 32'(wide_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
